// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM encoding, default
// wait timeout and the MEM/WB and latched-request record layouts.
package mem_stage_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DONE   = 2'd2,
    ST_HALTED = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [15:0] read_data;
    logic [15:0] alu_result;
    logic [15:0] pc_2;
    logic        mem_to_reg;
    logic        reg_write;
    logic        is_not_halt;
    logic [2:0]  write_reg_sel;
  } mem_wb_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pc_2;
    logic        rd;
    logic        mem_to_reg;
    logic        reg_write;
    logic        is_not_halt;
    logic [2:0]  write_reg_sel;
  } mem_req_t;

  // An empty MEM/WB slot must not look like a HALT, so isNotHalt idles high.
  function automatic mem_wb_t mem_wb_reset_value();
    mem_wb_t v;
    v             = '0;
    v.is_not_halt = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank with load enable.
module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_en,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  mem_wb_t r_q;

  // Bank update: load on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= mem_wb_reset_value();
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory strobes, stalls the pipeline
// while an access is outstanding and loads the MEM/WB register bank.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] aluResult_EX_MEM,
  input  logic [15:0] rdData2_EX_MEM,
  input  logic [15:0] PC_2_EX_MEM,
  input  logic        MemRead_EX_MEM,
  input  logic        MemWrite_EX_MEM,
  input  logic        MemToReg_EX_MEM,
  input  logic        RegWrite_EX_MEM,
  input  logic [2:0]  writeRegSel_EX_MEM,
  input  logic        isNotHalt_EX_MEM,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_done,
  output logic        stall,
  output logic [15:0] readData_MEM_WB,
  output logic [15:0] aluResult_MEM_WB,
  output logic [15:0] PC_2_MEM_WB,
  output logic        MemToReg_MEM_WB,
  output logic        RegWrite_MEM_WB,
  output logic        isNotHalt_MEM_WB,
  output logic [2:0]  writeRegSel_MEM_WB,
  output logic        err
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_set;
  logic          r_tmo, w_tmo_nxt;
  mem_req_t      r_req, w_req_nxt, w_in;
  logic [15:0]   r_rdata, w_rdata_nxt;
  logic          w_wb_en;
  mem_wb_t       w_wb_d, w_wb_q;
  logic          w_rd, w_wr, w_stall;
  logic [15:0]   w_addr, w_wdata;
  logic          w_req, w_bad;

  assign w_in = '{addr: aluResult_EX_MEM, wdata: rdData2_EX_MEM, pc_2: PC_2_EX_MEM,
                  rd: MemRead_EX_MEM, mem_to_reg: MemToReg_EX_MEM,
                  reg_write: RegWrite_EX_MEM, is_not_halt: isNotHalt_EX_MEM,
                  write_reg_sel: writeRegSel_EX_MEM};

  // Odd addresses and read+write together never reach the memory.
  assign w_req = MemRead_EX_MEM | MemWrite_EX_MEM;
  assign w_bad = w_req & (aluResult_EX_MEM[0] | (MemRead_EX_MEM & MemWrite_EX_MEM));

  // Next-state, strobe and MEM/WB load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_req_nxt   = r_req;
    w_rdata_nxt = r_rdata;
    w_err_set   = 1'b0;
    w_wb_en     = 1'b0;
    w_wb_d      = mem_wb_reset_value();
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_stall     = 1'b0;
    w_addr      = r_req.addr;
    w_wdata     = r_req.wdata;
    case (r_state)
      ST_IDLE: begin
        w_addr  = aluResult_EX_MEM;
        w_wdata = rdData2_EX_MEM;
        if (w_req && !w_bad) begin
          w_rd    = MemRead_EX_MEM;
          w_wr    = MemWrite_EX_MEM;
          w_stall = 1'b1;
          if (!mem_stall) begin
            w_req_nxt   = w_in;
            w_rdata_nxt = 16'h0000;
            w_cnt_nxt   = {CW{1'b0}};
            w_tmo_nxt   = 1'b0;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_err_set   = w_bad;
          w_wb_en     = 1'b1;
          w_wb_d      = '{read_data: 16'h0000, alu_result: aluResult_EX_MEM,
                          pc_2: PC_2_EX_MEM, mem_to_reg: MemToReg_EX_MEM,
                          reg_write: RegWrite_EX_MEM & ~w_bad,
                          is_not_halt: isNotHalt_EX_MEM,
                          write_reg_sel: writeRegSel_EX_MEM};
          w_state_nxt = isNotHalt_EX_MEM ? ST_IDLE : ST_HALTED;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (mem_done) begin
          w_rdata_nxt = r_req.rd ? mem_rdata : r_rdata;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_set   = 1'b1;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_wb_en     = 1'b1;
        w_wb_d      = '{read_data: r_rdata, alu_result: r_req.addr, pc_2: r_req.pc_2,
                        mem_to_reg: r_req.mem_to_reg,
                        reg_write: r_req.reg_write & ~r_tmo,
                        is_not_halt: r_req.is_not_halt,
                        write_reg_sel: r_req.write_reg_sel};
        w_state_nxt = r_req.is_not_halt ? ST_IDLE : ST_HALTED;
      end
      ST_HALTED: begin
        w_stall = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Controller state, wait counter, sticky error and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
      r_req   <= '0;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= r_err | w_err_set;
      r_tmo   <= w_tmo_nxt;
      r_req   <= w_req_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_wb_en),
    .i_d   (w_wb_d),
    .o_q   (w_wb_q)
  );

  // Strobes and stall are same-cycle, so reset must mask them directly.
  assign mem_rd    = w_rd & rst_n;
  assign mem_wr    = w_wr & rst_n;
  assign stall     = w_stall & rst_n;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;
  assign err       = r_err;

  assign readData_MEM_WB    = w_wb_q.read_data;
  assign aluResult_MEM_WB   = w_wb_q.alu_result;
  assign PC_2_MEM_WB        = w_wb_q.pc_2;
  assign MemToReg_MEM_WB    = w_wb_q.mem_to_reg;
  assign RegWrite_MEM_WB    = w_wb_q.reg_write;
  assign isNotHalt_MEM_WB   = w_wb_q.is_not_halt;
  assign writeRegSel_MEM_WB = w_wb_q.write_reg_sel;

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum number of WAIT cycles before error.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port aluResult_EX_MEM, input, 16, memory address or ALU result.
REQ-005 SHALL have port rdData2_EX_MEM, input, 16, store data.
REQ-006 SHALL have port PC_2_EX_MEM, input, 16, PC+2 passthrough.
REQ-007 SHALL have port MemRead_EX_MEM, input, 1, load request.
REQ-008 SHALL have port MemWrite_EX_MEM, input, 1, store request.
REQ-009 SHALL have port MemToReg_EX_MEM, input, 1, writeback select passthrough.
REQ-010 SHALL have port RegWrite_EX_MEM, input, 1, register write enable passthrough.
REQ-011 SHALL have port writeRegSel_EX_MEM, input, 3, destination register passthrough.
REQ-012 SHALL have port isNotHalt_EX_MEM, input, 1, low marks a HALT instruction.
REQ-013 SHALL have port mem_addr, output, 16, data memory address.
REQ-014 SHALL have port mem_wdata, output, 16, data memory write data.
REQ-015 SHALL have port mem_rd, output, 1, read strobe.
REQ-016 SHALL have port mem_wr, output, 1, write strobe.
REQ-017 SHALL have port mem_rdata, input, 16, memory read data, valid with mem_done.
REQ-018 SHALL have port mem_stall, input, 1, memory busy; a strobe is accepted only when mem_stall is low.
REQ-019 SHALL have port mem_done, input, 1, one-cycle completion pulse.
REQ-020 SHALL have port stall, output, 1, high freezes the upstream pipeline (drives EX_MEM enable low).
REQ-021 SHALL have ports readData_MEM_WB, aluResult_MEM_WB, PC_2_MEM_WB (output, 16 each), registered MEM/WB data.
REQ-022 SHALL have ports MemToReg_MEM_WB, RegWrite_MEM_WB, isNotHalt_MEM_WB (output, 1 each), registered MEM/WB controls.
REQ-023 SHALL have port writeRegSel_MEM_WB, output, 3, registered destination register.
REQ-024 SHALL have port err, output, 1, sticky memory error flag.

Function
REQ-025 SHALL implement FSM IDLE, WAIT, DONE, HALTED.
REQ-026 IDLE: when MemRead or MemWrite is high, SHALL drive mem_rd/mem_wr, mem_addr=aluResult_EX_MEM, mem_wdata=rdData2_EX_MEM, and stall=1 in the same cycle; if mem_stall=0, SHALL latch the request and go to WAIT, else stay in IDLE and re-drive next cycle.
REQ-027 IDLE with no request: stall=0; MEM/WB registers SHALL load EX_MEM inputs each cycle, readData_MEM_WB=0; single-cycle latency.
REQ-028 WAIT: strobes low, stall=1, address/data held from latch; on mem_done SHALL capture mem_rdata (loads only) and go to DONE.
REQ-029 DONE: stall=0; MEM/WB SHALL load the latched instruction with the captured data; next state IDLE; minimum memory-op latency is 3 cycles.
REQ-030 Misaligned address (aluResult_EX_MEM[0]=1) or MemRead and MemWrite both high SHALL issue no strobe, set err, and pass the instruction to MEM/WB with RegWrite_MEM_WB=0.
REQ-031 WAIT cycle counter reaching TIMEOUT without mem_done SHALL set err, force RegWrite_MEM_WB=0, and go to DONE.
REQ-032 mem_done in IDLE or DONE SHALL be ignored.
REQ-033 After an instruction with isNotHalt_EX_MEM=0 is loaded into MEM/WB, SHALL enter HALTED: no strobes, stall=1, MEM/WB frozen, until reset.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, counter 0, err=0, stall=0, strobes 0, all MEM/WB outputs 0 except isNotHalt_MEM_WB=1; an in-flight access is abandoned and a later mem_done is ignored.

Structure
REQ-035 FSM state encoding and the default TIMEOUT SHALL reside in the shared pipeline package; the MEM/WB register bank SHALL be one sub-module, mem_wb_reg, with an enable.

Verification
REQ-036 Load: addr 0x0040, MemRead=1, mem_done on 2nd WAIT cycle with rdata 0xBEEF -> readData_MEM_WB=0xBEEF, stall high 3 cycles.
REQ-037 Store with mem_stall high 2 cycles: addr 0x0010, data 0x1234 -> mem_wr held 3 cycles, one accepted write, stall released after mem_done.
REQ-038 Misaligned load at 0x0041 -> no mem_rd, err=1, RegWrite_MEM_WB=0.
REQ-039 No mem_done for TIMEOUT=16 WAIT cycles -> err=1 on the 16th cycle, FSM returns to IDLE via DONE.
REQ-040 rst_n pulsed low in WAIT, then mem_done -> outputs at reset values, no capture, FSM in IDLE.
